// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed program image over UART,
// writes it to program memory and holds the core in reset until the image verifies.
module uart_program_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned BREAK_BITS   = 20,
  localparam int unsigned WL_W        = $clog2(MEM_WORDS + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            io_rx,
  output logic [31:0]     mem_address,
  output logic            mem_write_enable,
  output logic [31:0]     mem_write_data,
  output logic            cpu_reset_n,
  output logic            load_done,
  output logic            load_error,
  output logic [WL_W-1:0] words_loaded
);

  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam int unsigned BRK_CYC = BREAK_BITS * CLKS_PER_BIT;
  localparam int unsigned BRK_W   = $clog2(BRK_CYC + 1);

  localparam logic [2:0] R_IDLE  = 3'd0;
  localparam logic [2:0] R_START = 3'd1;
  localparam logic [2:0] R_DATA  = 3'd2;
  localparam logic [2:0] R_STOP  = 3'd3;
  localparam logic [2:0] R_WAIT  = 3'd4;

  localparam logic [2:0] S_LEN   = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_CSUM  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   rx_s;
  logic                   rx_prev;
  logic [BRK_W-1:0]       low_cnt;
  logic                   brk;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             byte_valid;
  logic             frame_err;

  logic [2:0]       state;
  logic [1:0]       byte_cnt;
  logic [31:0]      word_sr;
  logic [31:0]      assembled;
  logic [WL_W-1:0]  n_words;
  logic [7:0]       csum;

  assign rx_s      = sync_ff[SYNC_STAGES-1];
  assign assembled = {rx_byte, word_sr[31:8]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], io_rx};
      rx_prev <= rx_s;
    end
  end

  // Saturating low-time counter; brk pulses once per continuous low period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      low_cnt <= '0;
      brk     <= 1'b0;
    end else begin
      brk <= 1'b0;
      if (rx_s) begin
        low_cnt <= '0;
      end else if (low_cnt != BRK_W'(BRK_CYC)) begin
        low_cnt <= low_cnt + 1'b1;
        if (low_cnt == BRK_W'(BRK_CYC - 1)) brk <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= R_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (brk) begin
        r_state <= R_WAIT;
      end else begin
        case (r_state)
          R_IDLE: begin
            if (rx_prev && !rx_s) begin
              r_state <= R_START;
              cnt     <= '0;
            end
          end
          R_START: begin
            if (cnt == HALF_LAST) begin
              cnt     <= '0;
              bit_idx <= '0;
              r_state <= rx_s ? R_IDLE : R_DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          R_DATA: begin
            if (cnt == BIT_LAST) begin
              cnt     <= '0;
              rx_byte <= {rx_s, rx_byte[7:1]};
              if (bit_idx == 3'd7) r_state <= R_STOP;
              else bit_idx <= bit_idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          R_STOP: begin
            if (cnt == BIT_LAST) begin
              cnt <= '0;
              if (rx_s) begin
                byte_valid <= 1'b1;
                r_state    <= R_IDLE;
              end else begin
                frame_err <= 1'b1;
                r_state   <= R_WAIT;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          R_WAIT: begin
            if (rx_s) r_state <= R_IDLE;
          end
          default: r_state <= R_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_LEN;
      byte_cnt         <= '0;
      word_sr          <= '0;
      n_words          <= '0;
      csum             <= '0;
      mem_address      <= '0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= '0;
      cpu_reset_n      <= 1'b0;
      load_done        <= 1'b0;
      load_error       <= 1'b0;
      words_loaded     <= '0;
    end else begin
      mem_write_enable <= 1'b0;
      if (brk) begin
        state        <= S_LEN;
        byte_cnt     <= '0;
        csum         <= '0;
        words_loaded <= '0;
        cpu_reset_n  <= 1'b0;
        load_done    <= 1'b0;
        load_error   <= 1'b0;
      end else if (frame_err && (state == S_LEN || state == S_DATA || state == S_CSUM)) begin
        state      <= S_ERROR;
        load_error <= 1'b1;
      end else if (byte_valid) begin
        case (state)
          S_LEN: begin
            byte_cnt <= byte_cnt + 1'b1;
            word_sr  <= assembled;
            if (byte_cnt == 2'd3) begin
              n_words <= assembled[WL_W-1:0];
              if (assembled > 32'(MEM_WORDS)) begin
                state      <= S_ERROR;
                load_error <= 1'b1;
              end else if (assembled == '0) begin
                state <= S_CSUM;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            csum     <= csum ^ rx_byte;
            byte_cnt <= byte_cnt + 1'b1;
            word_sr  <= assembled;
            if (byte_cnt == 2'd3) begin
              mem_write_enable <= 1'b1;
              mem_address      <= BASE_ADDR + (32'(words_loaded) << 2);
              mem_write_data   <= assembled;
              words_loaded     <= words_loaded + WL_W'(1);
              if (words_loaded + WL_W'(1) == n_words) state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (rx_byte == csum) begin
              state       <= S_DONE;
              load_done   <= 1'b1;
              cpu_reset_n <= 1'b1;
            end else begin
              state      <= S_ERROR;
              load_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
